// File: rtl/icache_direct_if.sv
// rtl/icache_direct_if.sv - datapath and memory instruction-port signals for icache_direct
interface icache_direct_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache, one word per frame
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int CACHE_FRAMES = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  icache_direct_if.slave        bus,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int IDX  = $clog2(CACHE_FRAMES);
  localparam int TAGW = 30 - IDX;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state, state_n;
  logic [CACHE_FRAMES-1:0] valid;
  logic [TAGW-1:0]   tags  [CACHE_FRAMES];
  logic [31:0]       data  [CACHE_FRAMES];

  logic [31:0]       word_addr;
  logic [IDX-1:0]    index;
  logic [TAGW-1:0]   tag;
  logic              match;
  logic              fill;
  logic              ihit;
  logic [31:0]       imemload;
  logic              iren;
  logic [31:0]       iaddr;

  assign word_addr = bus.imemaddr & ~32'h3;
  assign index     = word_addr[IDX+1:2];
  assign tag       = word_addr[31:IDX+2];
  assign match     = valid[index] && (tags[index] == tag);
  // Refill is suppressed while nRST is low so a late response cannot land.
  assign fill      = nRST && (state == FETCH) && !bus.iwait;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= state_n;
      if (fill) valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[index] <= tag;
      data[index] <= bus.iload;
    end
  end

  always_comb begin
    state_n  = state;
    ihit     = 1'b0;
    imemload = '0;
    iren     = 1'b0;
    iaddr    = '0;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (match) imemload = data[index];
          if (bus.imemREN && match) ihit = 1'b1;
          if (bus.imemREN && !match) state_n = FETCH;
        end
        FETCH: begin
          iren  = 1'b1;
          iaddr = word_addr;
          if (!bus.iwait) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.ihit     = ihit;
  assign bus.imemload = imemload;
  assign bus.iREN     = iren;
  assign bus.iaddr    = iaddr;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ihit) hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_n == FETCH) miss_count <= miss_count + 32'd1;
    end
  end
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif
endmodule
